// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: pairs or splits a decoded instruction pair by hazard.
// Optional issue-statistics counters are built only when SCHED_PERF_EN is defined.
module dual_issue_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [4:0]  rd1_i,
    input  logic        regwrite1_i,
    input  logic        mem1_i,
    input  logic        ctl1_i,
    input  logic [4:0]  rs4_i,
    input  logic [4:0]  rs5_i,
    input  logic [4:0]  rd2_i,
    input  logic        regwrite2_i,
    input  logic        mem2_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        issue1_o,
    output logic        issue2_o,
    output logic        hold_o,
    output logic [15:0] split_cnt_o,
    output logic [15:0] pair_cnt_o
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   conflict_c;
    logic   issue1_c;
    logic   issue2_c;
    logic   hold_c;
    logic   rd1_nz_c;

    // Hazard detection between slot-1 and slot-2; x0 never carries a dependency.
    always_comb begin
        rd1_nz_c   = (rd1_i != REG_W'(0));
        conflict_c = (regwrite1_i && rd1_nz_c && ((rd1_i == rs4_i) || (rd1_i == rs5_i)))
                   || (regwrite1_i && regwrite2_i && rd1_nz_c && (rd1_i == rd2_i))
                   || (mem1_i && mem2_i)
                   || ctl1_i;
    end

    // Next state and zero-latency issue controls; flush outranks stall.
    always_comb begin
        state_d  = state_q;
        issue1_c = 1'b0;
        issue2_c = 1'b0;
        hold_c   = 1'b0;
        if (flush_i) begin
            state_d = PAIR;
        end else if (stall_i) begin
            hold_c = 1'b1;
        end else begin
            case (state_q)
                PAIR: begin
                    if (valid_i) begin
                        issue1_c = 1'b1;
                        if (conflict_c) begin
                            hold_c  = 1'b1;
                            state_d = SECOND;
                        end else begin
                            issue2_c = 1'b1;
                        end
                    end
                end
                SECOND: begin
                    issue2_c = 1'b1;
                    state_d  = PAIR;
                end
                default: state_d = PAIR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAIR;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are forced low while reset is asserted, whatever the inputs do.
    assign issue1_o = issue1_c & rst_n;
    assign issue2_o = issue2_c & rst_n;
    assign hold_o   = hold_c & rst_n;

`ifdef SCHED_PERF_EN
    logic             pair_inc_c;
    logic             split_inc_c;
    logic [CNT_W-1:0] pair_q;
    logic [CNT_W-1:0] split_q;

    assign pair_inc_c  = issue1_c & issue2_c;
    assign split_inc_c = (state_q == SECOND) & issue2_c;

    // Saturating counters, one increment per completed pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q  <= '0;
            split_q <= '0;
        end else begin
            if (pair_inc_c && (pair_q != {CNT_W{1'b1}})) begin
                pair_q <= pair_q + CNT_W'(1);
            end
            if (split_inc_c && (split_q != {CNT_W{1'b1}})) begin
                split_q <= split_q + CNT_W'(1);
            end
        end
    end

    assign pair_cnt_o  = pair_q;
    assign split_cnt_o = split_q;
`else
    assign pair_cnt_o  = '0;
    assign split_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler; counter expectations follow SCHED_PERF_EN.
module tb_dual_issue_scheduler;
    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [4:0]  rd1_i;
    logic        regwrite1_i;
    logic        mem1_i;
    logic        ctl1_i;
    logic [4:0]  rs4_i;
    logic [4:0]  rs5_i;
    logic [4:0]  rd2_i;
    logic        regwrite2_i;
    logic        mem2_i;
    logic        stall_i;
    logic        flush_i;
    logic        issue1_o;
    logic        issue2_o;
    logic        hold_o;
    logic [15:0] split_cnt_o;
    logic [15:0] pair_cnt_o;

    typedef struct packed {
        logic i1;
        logic i2;
        logic hold;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    logic        m_second;
    int          m_pair;
    int          m_split;

    dual_issue_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .rd1_i       (rd1_i),
        .regwrite1_i (regwrite1_i),
        .mem1_i      (mem1_i),
        .ctl1_i      (ctl1_i),
        .rs4_i       (rs4_i),
        .rs5_i       (rs5_i),
        .rd2_i       (rd2_i),
        .regwrite2_i (regwrite2_i),
        .mem2_i      (mem2_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .issue1_o    (issue1_o),
        .issue2_o    (issue2_o),
        .hold_o      (hold_o),
        .split_cnt_o (split_cnt_o),
        .pair_cnt_o  (pair_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cnt_exp(input int v);
`ifdef SCHED_PERF_EN
        return (v > 65535) ? 65535 : v;
`else
        return v - v;
`endif
    endfunction

    function automatic logic has_conflict();
        logic raw;
        logic waw;
        raw = regwrite1_i && (rd1_i != 5'd0) && ((rd1_i == rs4_i) || (rd1_i == rs5_i));
        waw = regwrite1_i && regwrite2_i && (rd1_i != 5'd0) && (rd1_i == rd2_i);
        return raw || waw || (mem1_i && mem2_i) || ctl1_i;
    endfunction

    task automatic set_pair(input logic v, input logic [4:0] rd1, input logic rw1,
                            input logic m1, input logic c1, input logic [4:0] rs4,
                            input logic [4:0] rs5, input logic [4:0] rd2,
                            input logic rw2, input logic m2);
        valid_i = v; rd1_i = rd1; regwrite1_i = rw1; mem1_i = m1; ctl1_i = c1;
        rs4_i = rs4; rs5_i = rs5; rd2_i = rd2; regwrite2_i = rw2; mem2_i = m2;
    endtask

    // One cycle: predict, push, compare outputs mid-cycle, then compare counters after the edge.
    task automatic step(input string tag, input logic st, input logic fl, input logic chk_cnt);
        exp_t e;
        exp_t got;
        logic nxt;
        stall_i = st;
        flush_i = fl;
        e = '0;
        nxt = m_second;
        if (fl) begin
            nxt = 1'b0;
        end else if (st) begin
            e.hold = 1'b1;
        end else if (m_second) begin
            e.i2 = 1'b1;
            nxt = 1'b0;
            m_split++;
        end else if (valid_i) begin
            e.i1 = 1'b1;
            if (has_conflict()) begin
                e.hold = 1'b1;
                nxt = 1'b1;
            end else begin
                e.i2 = 1'b1;
                m_pair++;
            end
        end
        sb_q.push_back(e);
        #2;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            got = {issue1_o, issue2_o, hold_o};
            check({tag, "_issue"}, 32'(got), 32'(e));
        end
        @(posedge clk);
        #1;
        m_second = nxt;
        if (chk_cnt) begin
            check({tag, "_pair_cnt"}, 32'(pair_cnt_o), 32'(cnt_exp(m_pair)));
            check({tag, "_split_cnt"}, 32'(split_cnt_o), 32'(cnt_exp(m_split)));
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_second = 1'b0; m_pair = 0; m_split = 0;
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
        #3;
        check("rst_outputs", 32'({issue1_o, issue2_o, hold_o}), 32'd0);
        check("rst_pair_cnt", 32'(pair_cnt_o), 32'd0);
        check("rst_split_cnt", 32'(split_cnt_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_pair(1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
        step("idle", 1'b0, 1'b0, 1'b1);
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
        step("indep", 1'b0, 1'b0, 1'b1);
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 5'd7, 5'd8, 1'b1, 1'b0);
        step("raw_c0", 1'b0, 1'b0, 1'b1);
        step("raw_c1", 1'b0, 1'b0, 1'b1);
        set_pair(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        step("x0", 1'b0, 1'b0, 1'b1);
        set_pair(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        step("waw_c0", 1'b0, 1'b0, 1'b1);
        step("waw_c1", 1'b0, 1'b0, 1'b1);
        set_pair(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 5'd3, 5'd4, 1'b0, 1'b0);
        step("raw_rs5", 1'b0, 1'b0, 1'b1);
        step("raw_rs5_c1", 1'b0, 1'b0, 1'b1);
        set_pair(1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1);
        step("ldst_c0", 1'b0, 1'b0, 1'b1);
        step("ldst_stall0", 1'b1, 1'b0, 1'b1);
        step("ldst_stall1", 1'b1, 1'b0, 1'b1);
        step("ldst_c1", 1'b0, 1'b0, 1'b1);
        step("ldst_after", 1'b0, 1'b0, 1'b1);
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
        step("pair_stall", 1'b1, 1'b0, 1'b1);
        set_pair(1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
        step("br_c0", 1'b0, 1'b0, 1'b1);
        step("br_flush", 1'b1, 1'b1, 1'b1);
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
        step("br_next", 1'b0, 1'b0, 1'b1);
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 5'd7, 5'd8, 1'b1, 1'b0);
        step("flush_conf", 1'b0, 1'b1, 1'b1);
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
        step("flush_next", 1'b0, 1'b0, 1'b1);

        // Random traffic; the pair is held stable while slot-2 is pending.
        for (int i = 0; i < 300; i++) begin
            if (!m_second) begin
                set_pair(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                         ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                         1'($urandom));
            end
            step("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), 1'b1);
        end
        stall_i = 1'b0; flush_i = 1'b0;
        if (m_second) step("rand_drain", 1'b0, 1'b0, 1'b1);

`ifdef SCHED_PERF_EN
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            step("sat", 1'b0, 1'b0, 1'b0);
        end
        check("sat_pair_cnt", 32'(pair_cnt_o), 32'h0000_FFFF);
`endif

        // Reset asserted while slot-2 is pending.
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 5'd7, 5'd8, 1'b1, 1'b0);
        step("rstsec_c0", 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstsec_outputs", 32'({issue1_o, issue2_o, hold_o}), 32'd0);
        check("rstsec_pair_cnt", 32'(pair_cnt_o), 32'd0);
        check("rstsec_split_cnt", 32'(split_cnt_o), 32'd0);
        m_second = 1'b0; m_pair = 0; m_split = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_pair(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
        step("post_rst", 1'b0, 1'b0, 1'b1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_issue_scheduler.md
DUAL_ISSUE_SCHEDULER -- requirements
Module: dual_issue_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (asynchronous assert, active low).
REQ-002 clk  input  1  core clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 valid_i  input  1  decoded instruction pair present in decode.
REQ-005 rd1_i  input  5  slot-1 destination register.
REQ-006 regwrite1_i  input  1  slot-1 writes the register file.
REQ-007 mem1_i  input  1  slot-1 is a load or store.
REQ-008 ctl1_i  input  1  slot-1 is a branch or jump.
REQ-009 rs4_i, rs5_i  input  5 each  slot-2 source registers.
REQ-010 rd2_i  input  5  slot-2 destination register.
REQ-011 regwrite2_i  input  1  slot-2 writes the register file.
REQ-012 mem2_i  input  1  slot-2 is a load or store.
REQ-013 stall_i  input  1  downstream hazard stall; hold everything.
REQ-014 flush_i  input  1  squash the decode pair (taken branch or jump).
REQ-015 issue1_o  output  1  slot-1 enters execute this cycle.
REQ-016 issue2_o  output  1  slot-2 enters execute this cycle.
REQ-017 hold_o  output  1  freeze fetch and the decode register next edge.
REQ-018 split_cnt_o  output  16  count of split-issued pairs.
REQ-019 pair_cnt_o  output  16  count of pairs issued together.

Function
REQ-020 conflict SHALL be the OR of the following terms:
- RAW: regwrite1_i && rd1_i!=0 && (rd1_i==rs4_i || rd1_i==rs5_i).
- WAW: regwrite1_i && regwrite2_i && rd1_i!=0 && rd1_i==rd2_i.
- Structural: mem1_i && mem2_i.
- Control: ctl1_i.
REQ-021 The FSM SHALL have two states, PAIR and SECOND; outputs SHALL be combinational from state and inputs, giving zero-cycle issue latency.
REQ-022 PAIR, valid_i=0: issue1_o=issue2_o=hold_o=0; stay in PAIR.
REQ-023 PAIR, valid_i=1, conflict=0: issue1_o=issue2_o=1, hold_o=0; stay in PAIR.
REQ-024 PAIR, valid_i=1, conflict=1: issue1_o=1, issue2_o=0, hold_o=1; go to SECOND.
REQ-025 SECOND: issue1_o=0, issue2_o=1, hold_o=0; go to PAIR. Conflict is not re-evaluated because the inputs are held.
REQ-026 stall_i=1 (with flush_i=0): issue1_o=issue2_o=0, hold_o=1; state unchanged; counters unchanged.
REQ-027 flush_i=1 SHALL have priority over stall_i and all other conditions: issue1_o=issue2_o=hold_o=0; next state PAIR. A pending slot-2 in SECOND is discarded.
REQ-028 A flush in the same cycle as a PAIR conflict SHALL NOT enter SECOND.
REQ-029 Counters SHALL increment once per pair, on the edge where the issue completes:
- pair_cnt_o: on a REQ-023 cycle.
- split_cnt_o: on the SECOND cycle that issues slot-2.
REQ-030 Both counters SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-031 While rst_n=0, the state SHALL be PAIR, split_cnt_o=0 and pair_cnt_o=0, asynchronously.
REQ-032 While rst_n=0, issue1_o, issue2_o and hold_o SHALL be 0, independent of inputs.
REQ-033 Reset asserted in SECOND SHALL drop the pending slot-2; the first cycle after deassertion is PAIR.

Configuration
REQ-034 Macro SCHED_PERF_EN: when defined, the counters SHALL behave per REQ-029/REQ-030.
REQ-035 When SCHED_PERF_EN is undefined, no counter flops SHALL be built and split_cnt_o and pair_cnt_o SHALL be constant 0. Scheduling behaviour SHALL be identical in both builds.

Verification
REQ-036 Independent pair: rd1=5 with regwrite1, rs4=6, rs5=7, valid -> issue1=issue2=1, hold=0; pair_cnt 0->1.
REQ-037 RAW: rd1=5 with regwrite1, rs4=5 -> cycle0 issue1=1, hold=1; cycle1 issue2=1, hold=0; split_cnt 0->1.
REQ-038 x0 exemption: rd1=0 with regwrite1, rs4=0 -> dual issue, no split.
REQ-039 Load+store pair (mem1=mem2=1) with stall_i=1 on the SECOND cycle -> issue2 held low and state held; after stall_i drops, issue2=1 for exactly one cycle.
REQ-040 Branch in slot-1 (ctl1=1), then flush_i=1 in SECOND -> issue2 never asserts; next cycle is PAIR; split_cnt unchanged.
REQ-041 With SCHED_PERF_EN, 65540 independent pairs -> pair_cnt_o=16'hFFFF. Reset mid-SECOND -> all outputs 0 immediately and counters 0.
